// File: rtl/mac_rx_if.sv
// -----------------------------------------------------------------------------
// mac_rx_if: signal bundle between the 10BASE-T receive framer, the PLS
// receive decoder and the MAC receive buffer.
//
//   crs       PLS -> framer   carrier sense, high for the whole burst
//   rxdv      PLS -> framer   one-cycle strobe marking a valid bit on rxd
//   rxd       PLS -> framer   decoded receive bit
//   rx_ack    bus -> framer   one-cycle "buffer consumed" pulse
//   buf_we    framer -> buf   buffer write strobe
//   buf_addr  framer -> buf   buffer word address (word 0 = status)
//   buf_dat   framer -> buf   buffer write data
//   rxfull    framer -> bus   frame available / interrupt source
//
// master: the framer side. slave: the PLS/buffer/bus environment.
// -----------------------------------------------------------------------------
interface mac_rx_if;
    logic        crs;
    logic        rxdv;
    logic        rxd;
    logic        rx_ack;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [31:0] buf_dat;
    logic        rxfull;

    modport master (
        input  crs, rxdv, rxd, rx_ack,
        output buf_we, buf_addr, buf_dat, rxfull
    );

    modport slave (
        output crs, rxdv, rxd, rx_ack,
        input  buf_we, buf_addr, buf_dat, rxfull
    );
endinterface

// File: rtl/mac_rx.sv
// -----------------------------------------------------------------------------
// mac_rx: 10BASE-T receive framer.
//
// Strips preamble/SFD from the decoded bit stream, packs frame bits LSB-first
// into 32-bit buffer words starting at word 1, runs the serial FCS check and
// writes a length/status word to word 0, then holds rxfull until rx_ack.
//
// Ports:
//   clk_20mhz  bit-rate clock (only clock)
//   rst_i      asynchronous, active-high reset
//   bus        mac_rx_if.master (crs/rxdv/rxd/rx_ack in,
//              buf_we/buf_addr/buf_dat/rxfull out, all registered)
//
// Status word: [11:0] byte length (incl. FCS, saturating at 4095),
//   [16] crc_ok, [17] runt, [18] too_long, [19] dribble, [31:24] dropcnt.
// -----------------------------------------------------------------------------
module mac_rx (
    input  logic     clk_20mhz,
    input  logic     rst_i,
    mac_rx_if.master bus
);

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_FLUSH,
        S_STATUS,
        S_DISCARD
    } state_t;

    state_t      state_q,     state_d;
    logic        crs_q,       crs_d;
    logic [2:0]  pre_cnt_q,   pre_cnt_d;     // alternating preamble bits seen, saturating
    logic        prev_bit_q,  prev_bit_d;
    logic [14:0] bitcnt_q,    bitcnt_d;
    logic [31:0] crc_q,       crc_d;
    logic [31:0] crc_byte_q,  crc_byte_d;
    logic [31:0] word_q,      word_d;
    logic        too_long_q,  too_long_d;
    logic [7:0]  dropcnt_q,   dropcnt_d;
    logic        buf_we_q,    buf_we_d;
    logic [8:0]  buf_addr_q,  buf_addr_d;
    logic [31:0] buf_dat_q,   buf_dat_d;
    logic        rxfull_q,    rxfull_d;
    logic        status_wr_q, status_wr_d;   // status word is on the bus this cycle

    logic [31:0] crc_next;
    logic [14:0] bitcnt_inc;
    logic [31:0] word_ins;
    logic [10:0] flush_addr;
    logic [11:0] len_bytes;
    logic [31:0] status_word;

    assign crc_next = (crc_q[31] ^ bus.rxd) ? ({crc_q[30:0], 1'b0} ^ CRC_POLY)
                                            :  {crc_q[30:0], 1'b0};

    assign bitcnt_inc = (bitcnt_q == 15'h7FFF) ? bitcnt_q : bitcnt_q + 15'd1;

    // One extra address bit so a flush past word 1023 is still seen as oversize.
    assign flush_addr = {1'b0, bitcnt_q[14:5]} + 11'd1;

    // A 15-bit count shifted right by 3 never exceeds 4095, so this saturates by itself.
    assign len_bytes = bitcnt_q[14:3];

    assign status_word = {dropcnt_q,
                          4'b0000,
                          (bitcnt_q[2:0] != 3'd0),
                          too_long_q,
                          (len_bytes < 12'd64),
                          (crc_byte_q == CRC_RESIDUE),
                          4'b0000,
                          len_bytes};

    // NOTE: every variable written in an always_comb gets a value before any
    // branch; otherwise a path that skips it infers a latch.
    always_comb begin
        word_ins                  = word_q;
        word_ins[bitcnt_q[4:0]]   = bus.rxd;
    end

    always_comb begin
        state_d     = state_q;
        crs_d       = bus.crs;
        pre_cnt_d   = pre_cnt_q;
        prev_bit_d  = prev_bit_q;
        bitcnt_d    = bitcnt_q;
        crc_d       = crc_q;
        crc_byte_d  = crc_byte_q;
        word_d      = word_q;
        too_long_d  = too_long_q;
        dropcnt_d   = dropcnt_q;
        buf_we_d    = 1'b0;
        buf_addr_d  = buf_addr_q;
        buf_dat_d   = buf_dat_q;
        status_wr_d = 1'b0;

        // Set has priority so an ack racing the status write cannot lose a frame.
        if (status_wr_q) begin
            rxfull_d = 1'b1;
        end else if (bus.rx_ack) begin
            rxfull_d = 1'b0;
        end else begin
            rxfull_d = rxfull_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.crs && !crs_q) begin
                    // status_wr_q covers the one cycle before rxfull_q catches up.
                    if (rxfull_q || status_wr_q) begin
                        state_d = S_DISCARD;
                        if (dropcnt_q != 8'hFF) begin
                            dropcnt_d = dropcnt_q + 8'd1;
                        end
                    end else begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = 3'd0;
                    end
                end
            end

            S_PREAMBLE: begin
                if (!bus.crs) begin
                    state_d = S_IDLE;
                end else if (bus.rxdv) begin
                    prev_bit_d = bus.rxd;
                    if (pre_cnt_q != 3'd0 && bus.rxd == prev_bit_q) begin
                        // "11" after a long enough alternating run is the SFD tail.
                        if (bus.rxd && pre_cnt_q >= 3'd6) begin
                            state_d    = S_DATA;
                            bitcnt_d   = 15'd0;
                            crc_d      = CRC_INIT;
                            crc_byte_d = CRC_INIT;
                            word_d     = 32'd0;
                            too_long_d = 1'b0;
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end else if (pre_cnt_q != 3'd7) begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                end
            end

            S_DATA: begin
                // A bit coincident with carrier loss is still taken before flushing.
                if (bus.rxdv) begin
                    word_d   = word_ins;
                    crc_d    = crc_next;
                    bitcnt_d = bitcnt_inc;
                    if (bitcnt_inc[2:0] == 3'd0) begin
                        crc_byte_d = crc_next;
                    end
                    if (bitcnt_inc[4:0] == 5'd0) begin
                        word_d = 32'd0;
                        if (bitcnt_inc[14:5] > 10'd511) begin
                            too_long_d = 1'b1;
                        end else begin
                            buf_we_d   = 1'b1;
                            buf_addr_d = bitcnt_inc[13:5];
                            buf_dat_d  = word_ins;
                        end
                    end
                end
                if (!bus.crs) begin
                    state_d = S_FLUSH;
                end
            end

            S_FLUSH: begin
                if (bitcnt_q[4:0] != 5'd0) begin
                    if (flush_addr > 11'd511) begin
                        too_long_d = 1'b1;
                    end else begin
                        buf_we_d   = 1'b1;
                        buf_addr_d = flush_addr[8:0];
                        buf_dat_d  = word_q;
                    end
                end
                state_d = S_STATUS;
            end

            S_STATUS: begin
                buf_we_d    = 1'b1;
                buf_addr_d  = 9'd0;
                buf_dat_d   = status_word;
                status_wr_d = 1'b1;
                dropcnt_d   = 8'd0;
                state_d     = S_IDLE;
            end

            S_DISCARD: begin
                if (!bus.crs) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk_20mhz or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            crs_q       <= 1'b0;
            pre_cnt_q   <= 3'd0;
            prev_bit_q  <= 1'b0;
            bitcnt_q    <= 15'd0;
            crc_q       <= 32'd0;
            crc_byte_q  <= 32'd0;
            word_q      <= 32'd0;
            too_long_q  <= 1'b0;
            dropcnt_q   <= 8'd0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= 9'd0;
            buf_dat_q   <= 32'd0;
            rxfull_q    <= 1'b0;
            status_wr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crs_q       <= crs_d;
            pre_cnt_q   <= pre_cnt_d;
            prev_bit_q  <= prev_bit_d;
            bitcnt_q    <= bitcnt_d;
            crc_q       <= crc_d;
            crc_byte_q  <= crc_byte_d;
            word_q      <= word_d;
            too_long_q  <= too_long_d;
            dropcnt_q   <= dropcnt_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_dat_q   <= buf_dat_d;
            rxfull_q    <= rxfull_d;
            status_wr_q <= status_wr_d;
        end
    end

    assign bus.buf_we   = buf_we_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_dat  = buf_dat_q;
    assign bus.rxfull   = rxfull_q;

endmodule

// File: tb/tb_mac_rx.sv
// -----------------------------------------------------------------------------
// tb_mac_rx: directed + randomized bench for mac_rx.
// Frames are built as byte/bit lists; expected buffer contents and status
// words are derived from those lists with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mac_rx;

    logic clk_20mhz = 1'b0;
    logic rst_i;

    mac_rx_if bus ();

    mac_rx dut (
        .clk_20mhz (clk_20mhz),
        .rst_i     (rst_i),
        .bus       (bus)
    );

    always #25 clk_20mhz = ~clk_20mhz;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] dat;
    } wr_t;

    wr_t        wq[$];          // every buffer write seen on the bus
    logic [7:0] pay[$];         // payload bytes of the current frame
    bit         data_bits[$];   // bits after the SFD, in wire order
    bit         tx_bits[$];     // full wire stream incl. preamble/SFD
    logic [7:0] exp_drop;

    always @(negedge clk_20mhz) begin
        if (bus.buf_we === 1'b1) wq.push_back({bus.buf_addr, bus.buf_dat});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_20mhz);
        #1;
    endtask

    // Reference FCS: remainder of the message (init all ones) under 0x04C11DB7.
    function automatic logic [31:0] crc_bits(input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[31] ^ data_bits[i];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
        end
        return c;
    endfunction

    task automatic build_frame(input int n_pay, input bit add_fcs, input int flip,
                               input int n_drib, input bit reuse);
        logic [31:0] c;
        logic [7:0]  sfd;
        if (!reuse) begin
            pay.delete();
            repeat (n_pay) pay.push_back(8'($urandom));
        end
        data_bits.delete();
        foreach (pay[i]) for (int b = 0; b < 8; b++) data_bits.push_back(pay[i][b]);
        if (add_fcs) begin
            c = crc_bits(data_bits.size());
            for (int b = 31; b >= 0; b--) data_bits.push_back(~c[b]);
        end
        if (flip >= 0) data_bits[flip] = ~data_bits[flip];
        repeat (n_drib) data_bits.push_back(1'($urandom));
        tx_bits.delete();
        for (int i = 0; i < 56; i++) tx_bits.push_back(i % 2 == 0);
        sfd = 8'hD5;
        for (int b = 0; b < 8; b++) tx_bits.push_back(sfd[b]);
        foreach (data_bits[i]) tx_bits.push_back(data_bits[i]);
    endtask

    // Returns one cycle after the edge that samples crs low.
    task automatic send_frame(input bit coin);
        bus.crs = 1'b1;
        tick();
        foreach (tx_bits[i]) begin
            bus.rxdv = 1'b1;
            bus.rxd  = tx_bits[i];
            if (coin && i == tx_bits.size() - 1) bus.crs = 1'b0;
            tick();
            bus.rxdv = 1'b0;
            if (!(coin && i == tx_bits.size() - 1)) tick();
        end
        if (!coin) begin
            bus.crs = 1'b0;
            tick();
        end
    endtask

    task automatic finish_accepted(input string name, input bit tie);
        tick();
        tick();
        check({name, " status_we_timing"}, bus.buf_we, 1);
        check({name, " status_addr_timing"}, bus.buf_addr, 0);
        check({name, " rxfull_not_yet"}, bus.rxfull, 0);
        if (tie) bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
        check({name, " rxfull_rise"}, bus.rxfull, 1);
        repeat (4) tick();
    endtask

    task automatic check_accepted(input string name);
        int          n, nw, n_exp, len;
        logic [31:0] w, st;
        n     = data_bits.size();
        nw    = (n + 31) / 32;
        n_exp = (nw > 511) ? 511 : nw;
        check({name, " write_count"}, wq.size(), n_exp + 1);
        for (int k = 1; k <= n_exp && k < wq.size(); k++) begin
            w = '0;
            for (int j = 0; j < 32; j++)
                if (32 * (k - 1) + j < n) w[j] = data_bits[32 * (k - 1) + j];
            check($sformatf("%s addr_w%0d", name, k), wq[k-1].addr, k);
            check($sformatf("%s data_w%0d", name, k), wq[k-1].dat, w);
        end
        len = n / 8;
        if (len > 4095) len = 4095;
        st = {exp_drop, 4'b0000, (n % 8) != 0, nw > 511, len < 64,
              crc_bits(8 * (n / 8)) == 32'hC704_DD7B, 4'b0000, 12'(len)};
        if (wq.size() > 0) begin
            check({name, " status_addr"}, wq[wq.size()-1].addr, 0);
            check({name, " status_word"}, wq[wq.size()-1].dat, st);
        end
        exp_drop = 8'd0;
    endtask

    task automatic ack(input string name);
        bus.rx_ack = 1'b1;
        tick();
        bus.rx_ack = 1'b0;
        check({name, " rxfull_after_ack"}, bus.rxfull, 0);
    endtask

    task automatic run_valid(input string name, input bit coin, input bit tie);
        wq.delete();
        send_frame(coin);
        finish_accepted(name, tie);
        check_accepted(name);
    endtask

    task automatic run_ignored(input string name, input logic exp_full);
        wq.delete();
        send_frame(1'b0);
        repeat (6) tick();
        check({name, " no_writes"}, wq.size(), 0);
        check({name, " rxfull"}, bus.rxfull, exp_full);
    endtask

    initial begin
        bus.crs    = 1'b0;
        bus.rxdv   = 1'b0;
        bus.rxd    = 1'b0;
        bus.rx_ack = 1'b0;
        exp_drop   = 8'd0;
        rst_i      = 1'b1;
        #3;
        check("reset buf_we", bus.buf_we, 0);
        check("reset buf_addr", bus.buf_addr, 0);
        check("reset buf_dat", bus.buf_dat, 0);
        check("reset rxfull", bus.rxfull, 0);
        #60 rst_i = 1'b0;
        repeat (3) tick();

        // Valid 64-byte frame.
        build_frame(60, 1'b1, -1, 0, 1'b0);
        check("model valid fcs", crc_bits(data_bits.size()), 32'hC704_DD7B);
        run_valid("valid", 1'b0, 1'b0);
        ack("valid");

        // Same payload, bit 100 inverted; rx_ack coincides with the status write.
        build_frame(60, 1'b1, 100, 0, 1'b1);
        run_valid("badfcs", 1'b0, 1'b1);
        ack("badfcs");

        // Runt with 3 dribble bits, last bit coincident with carrier loss.
        build_frame(10, 1'b0, -1, 3, 1'b0);
        run_valid("runt", 1'b1, 1'b0);

        // Frame arriving while rxfull=1 is dropped and counted.
        build_frame(60, 1'b1, -1, 0, 1'b0);
        run_ignored("drop", 1'b1);
        exp_drop = 8'd1;
        ack("drop");
        build_frame(60, 1'b1, -1, 0, 1'b0);
        run_valid("after_drop", 1'b0, 1'b0);
        ack("after_drop");

        // Preamble errors: "00" mid-preamble, early "11", carrier loss in preamble.
        build_frame(60, 1'b1, -1, 0, 1'b0);
        tx_bits[4] = 1'b0;
        run_ignored("pre_00", 1'b0);
        build_frame(60, 1'b1, -1, 0, 1'b0);
        tx_bits[3] = 1'b1;
        run_ignored("pre_11_early", 1'b0);
        build_frame(60, 1'b1, -1, 0, 1'b0);
        while (tx_bits.size() > 30) void'(tx_bits.pop_back());
        run_ignored("pre_crs_drop", 1'b0);

        // Oversize: 2100 bytes including FCS.
        build_frame(2096, 1'b1, -1, 0, 1'b0);
        run_valid("oversize", 1'b0, 1'b0);
        if (wq.size() >= 2) check("oversize last_data_addr", wq[wq.size()-2].addr, 511);
        ack("oversize");

        // Randomized frames.
        for (int r = 0; r < 3; r++) begin
            build_frame(int'($urandom_range(46, 120)), 1'b1, -1,
                        int'($urandom_range(0, 7)), 1'b0);
            run_valid($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0);
            ack($sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of DATA.
        build_frame(60, 1'b1, -1, 0, 1'b0);
        bus.crs = 1'b1;
        tick();
        for (int i = 0; i < 56 + 8 + 100; i++) begin
            bus.rxdv = 1'b1;
            bus.rxd  = tx_bits[i];
            tick();
            bus.rxdv = 1'b0;
            tick();
        end
        #10 rst_i = 1'b1;
        #1;
        check("midreset buf_we", bus.buf_we, 0);
        check("midreset buf_addr", bus.buf_addr, 0);
        check("midreset buf_dat", bus.buf_dat, 0);
        check("midreset rxfull", bus.rxfull, 0);
        #20 rst_i = 1'b0;
        bus.crs  = 1'b0;
        exp_drop = 8'd0;
        repeat (5) tick();
        build_frame(60, 1'b1, -1, 0, 1'b0);
        run_valid("post_reset", 1'b0, 1'b0);
        ack("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
